// File: rtl/c1_zone_decode_if.sv
// 68k-side bus bundle for the C1 zone decoder: CPU address/strobe inputs,
// DTACK feedback from the wait generator, and the decoded zone outputs.
interface c1_zone_decode_if;
  logic [22:0] M68K_ADDR;
  logic        nAS;
  logic        M68K_RW;
  logic        nVEC;
  logic        nDTACK;
  logic        nROM_ZONE;
  logic        nWRAM_ZONE;
  logic        nPORT_ZONE;
  logic        nIO_ZONE;
  logic        nCARD_ZONE;
  logic        nSROM_ZONE;
  logic        nVALID;
  logic        nBERR;
  logic        LATCHED_RW;

  modport master (
    output M68K_ADDR, nAS, M68K_RW, nVEC, nDTACK,
    input  nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE,
    input  nVALID, nBERR, LATCHED_RW
  );

  modport slave (
    input  M68K_ADDR, nAS, M68K_RW, nVEC, nDTACK,
    output nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE,
    output nVALID, nBERR, LATCHED_RW
  );
endinterface

// File: rtl/c1_zone_decode.sv
// C1 zone decoder: latches the 68k address at bus-cycle start, decodes it
// into active-low zone selects, and times out cycles lacking nDTACK.
module c1_zone_decode #(
  parameter int BERR_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  c1_zone_decode_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, ERROR} state_t;

  localparam logic [CNT_W:0] TMO = (CNT_W+1)'(BERR_TIMEOUT);

  // zone vector bit order: {ROM, WRAM, PORT, IO, CARD, SROM}, active low
  state_t           state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [22:0]      addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [5:0]       zone_q, zone_d;
  logic             nvalid_q, nvalid_d;
  logic             nberr_q, nberr_d;
  // set by reset: a strobe already low must be raised before a new cycle
  logic             wait_rise_q, wait_rise_d;
  logic [CNT_W:0]   wdog_inc;

  function automatic logic [5:0] decode(input logic [22:0] a, input logic nvec);
    logic [5:0] z;
    z = 6'b111111;
    case (a[22:19])
      4'h0: if (!nvec && a[22:6] == 17'd0) z[0] = 1'b0;
            else                          z[5] = 1'b0;
      4'h1: z[4] = 1'b0;
      4'h2: z[3] = 1'b0;
      4'h3: z[2] = 1'b0;
      4'h8, 4'h9, 4'hA, 4'hB: z[1] = 1'b0;
      4'hC: z[0] = 1'b0;
      default: ;
    endcase
    return z;
  endfunction

  assign wdog_inc = {1'b0, wdog_q} + 1'b1;

  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    zone_d      = zone_q;
    nvalid_d    = nvalid_q;
    nberr_d     = nberr_q;
    wait_rise_d = wait_rise_q & ~bus.nAS;
    case (state_q)
      IDLE: begin
        if (!bus.nAS && !wait_rise_q) begin
          state_d  = ACTIVE;
          addr_d   = bus.M68K_ADDR;
          rw_d     = bus.M68K_RW;
          zone_d   = decode(bus.M68K_ADDR, bus.nVEC);
          nvalid_d = 1'b0;
          wdog_d   = '0;
        end
      end
      ACTIVE: begin
        if (bus.nAS) begin
          state_d = IDLE;
        end else if (!bus.nDTACK) begin
          state_d = HOLD;
        end else if (wdog_inc >= TMO) begin
          state_d = ERROR;
          nberr_d = 1'b0;
          wdog_d  = CNT_W'(BERR_TIMEOUT);
        end else begin
          wdog_d = wdog_inc[CNT_W-1:0];
        end
      end
      HOLD:    if (bus.nAS) state_d = IDLE;
      ERROR:   if (bus.nAS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // any exit to IDLE releases every select in the same edge
    if (state_q != IDLE && state_d == IDLE) begin
      wdog_d   = '0;
      zone_d   = 6'b111111;
      nvalid_d = 1'b1;
      nberr_d  = 1'b1;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b1;
      zone_q      <= 6'b111111;
      nvalid_q    <= 1'b1;
      nberr_q     <= 1'b1;
      wait_rise_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      zone_q      <= zone_d;
      nvalid_q    <= nvalid_d;
      nberr_q     <= nberr_d;
      wait_rise_q <= wait_rise_d;
    end
  end

  assign bus.nROM_ZONE  = zone_q[5];
  assign bus.nWRAM_ZONE = zone_q[4];
  assign bus.nPORT_ZONE = zone_q[3];
  assign bus.nIO_ZONE   = zone_q[2];
  assign bus.nCARD_ZONE = zone_q[1];
  assign bus.nSROM_ZONE = zone_q[0];
  assign bus.nVALID     = nvalid_q;
  assign bus.nBERR      = nberr_q;
  assign bus.LATCHED_RW = rw_q;

endmodule

// File: tb/tb_c1_zone_decode.sv
// Directed bench for c1_zone_decode: table of decode vectors run as full bus
// cycles, plus hand sequences for timeout, DTACK race, mid-cycle reset.
module tb_c1_zone_decode;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  c1_zone_decode_if bus();

  c1_zone_decode #(.BERR_TIMEOUT(64), .CNT_W(7)) dut (
    .CLK_68KCLK (clk),
    .RESET      (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] baddr;
    logic        rw;
    logic        nvec;
    logic [5:0]  zones;   // {ROM,WRAM,PORT,IO,CARD,SROM}
  } vec_t;

  vec_t vecs[13];

  // {zones, nVALID, nBERR, LATCHED_RW}
  function automatic logic [8:0] outs();
    return {bus.nROM_ZONE, bus.nWRAM_ZONE, bus.nPORT_ZONE, bus.nIO_ZONE,
            bus.nCARD_ZONE, bus.nSROM_ZONE, bus.nVALID, bus.nBERR, bus.LATCHED_RW};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (zones,nVALID,nBERR,RW)", name, act, exp);
    end
  endtask

  task automatic start(input logic [23:0] baddr, input logic rw, input logic nvec);
    bus.M68K_ADDR = baddr[23:1];
    bus.M68K_RW   = rw;
    bus.nVEC      = nvec;
    bus.nAS       = 1'b0;
    tick();
  endtask

  task automatic end_cycle();
    bus.nAS    = 1'b1;
    bus.nDTACK = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{24'h000400, 1'b1, 1'b1, 6'b011111};
    vecs[1]  = '{24'h000010, 1'b1, 1'b0, 6'b111110};
    vecs[2]  = '{24'h000080, 1'b1, 1'b0, 6'b011111};
    vecs[3]  = '{24'h8F0000, 1'b0, 1'b1, 6'b111101};
    vecs[4]  = '{24'h1FFFFE, 1'b1, 1'b1, 6'b101111};
    vecs[5]  = '{24'h200000, 1'b0, 1'b1, 6'b110111};
    vecs[6]  = '{24'h3ABCDE, 1'b1, 1'b1, 6'b111011};
    vecs[7]  = '{24'hBFFFFE, 1'b1, 1'b1, 6'b111101};
    vecs[8]  = '{24'hC00000, 1'b1, 1'b0, 6'b111110};
    vecs[9]  = '{24'h500000, 1'b1, 1'b1, 6'b111111};
    vecs[10] = '{24'hE00000, 1'b0, 1'b1, 6'b111111};
    vecs[11] = '{24'h00007E, 1'b1, 1'b0, 6'b111110};
    vecs[12] = '{24'h0FFFFE, 1'b1, 1'b0, 6'b011111};

    rst           = 1'b1;
    bus.M68K_ADDR = '0;
    bus.nAS       = 1'b1;
    bus.M68K_RW   = 1'b1;
    bus.nVEC      = 1'b1;
    bus.nDTACK    = 1'b1;
    tick();
    tick();
    chk("reset_state", 9'b111111_1_1_1);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 9'b111111_1_1_1);

    // table: full cycle per vector, DTACK after 3 clocks in ACTIVE
    for (int i = 0; i < 13; i++) begin
      start(vecs[i].baddr, vecs[i].rw, vecs[i].nvec);
      chk($sformatf("v%0d_entry", i), {vecs[i].zones, 1'b0, 1'b1, vecs[i].rw});
      tick();
      tick();
      chk($sformatf("v%0d_active", i), {vecs[i].zones, 1'b0, 1'b1, vecs[i].rw});
      bus.nDTACK = 1'b0;
      tick();
      bus.nDTACK = 1'b1;
      tick();
      chk($sformatf("v%0d_hold", i), {vecs[i].zones, 1'b0, 1'b1, vecs[i].rw});
      end_cycle();
      chk($sformatf("v%0d_idle", i), {6'b111111, 1'b1, 1'b1, vecs[i].rw});
      tick();
    end

    // mid-cycle address/RW change does not disturb the latched decode
    start(24'h8F0000, 1'b0, 1'b1);
    bus.M68K_ADDR = 23'h080000;   // byte 0x100000
    bus.M68K_RW   = 1'b1;
    tick();
    tick();
    chk("card_addr_change", 9'b111101_0_1_0);
    bus.nDTACK = 1'b0;
    tick();
    chk("card_hold", 9'b111101_0_1_0);
    end_cycle();
    chk("card_idle", 9'b111111_1_1_0);

    // nDTACK low while IDLE is ignored
    bus.nDTACK = 1'b0;
    tick();
    tick();
    chk("idle_dtack_ignored", 9'b111111_1_1_0);
    bus.nDTACK = 1'b1;
    tick();

    // watchdog timeout on unmapped 0x500000: nBERR exactly 64 clocks after entry
    start(24'h500000, 1'b1, 1'b1);
    for (int k = 1; k < 64; k++) tick();
    chk("timeout_edge63", 9'b111111_0_1_1);
    tick();
    chk("timeout_edge64", 9'b111111_0_0_1);
    for (int k = 0; k < 5; k++) tick();
    chk("error_held", 9'b111111_0_0_1);
    bus.nDTACK = 1'b0;
    tick();
    chk("error_ignores_dtack", 9'b111111_0_0_1);
    end_cycle();
    chk("error_exit", 9'b111111_1_1_1);
    tick();
    // new cycle after error: watchdog restarted from 0
    start(24'h000400, 1'b1, 1'b1);
    chk("after_error_rom", 9'b011111_0_1_1);
    for (int k = 1; k < 64; k++) tick();
    chk("after_error_wdog63", 9'b011111_0_1_1);
    end_cycle();
    tick();

    // nDTACK on the exact timeout edge wins
    start(24'h100000, 1'b1, 1'b1);
    for (int k = 1; k < 64; k++) tick();
    bus.nDTACK = 1'b0;
    tick();
    chk("dtack_race", 9'b101111_0_1_1);
    bus.nDTACK = 1'b1;
    for (int k = 0; k < 70; k++) tick();
    chk("dtack_race_hold", 9'b101111_0_1_1);
    end_cycle();
    chk("dtack_race_idle", 9'b111111_1_1_1);
    tick();

    // aborted cycle: nAS rises in ACTIVE
    start(24'h300000, 1'b0, 1'b1);
    tick();
    end_cycle();
    chk("abort_idle", 9'b111111_1_1_0);
    tick();

    // reset mid-ACTIVE with nAS held low
    start(24'h200000, 1'b1, 1'b1);
    tick();
    chk("port_active", 9'b110111_0_1_1);
    rst = 1'b1;
    tick();
    chk("mid_reset", 9'b111111_1_1_1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("no_restart_nas_low", 9'b111111_1_1_1);
    bus.nAS = 1'b1;
    tick();
    start(24'h200000, 1'b1, 1'b1);
    chk("restart_port", 9'b110111_0_1_1);
    for (int k = 1; k < 64; k++) tick();
    chk("restart_wdog63", 9'b110111_0_1_1);
    tick();
    chk("restart_wdog64", 9'b110111_0_0_1);
    end_cycle();
    chk("restart_idle", 9'b111111_1_1_1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c1_zone_decode.md
Name: c1_zone_decode

Overview:
Upstream neighbour of the C1 wait-state generator. Samples the 68k address at the start of each bus cycle and holds it for the whole cycle. Decodes that held address into the active-low zone selects consumed by the wait generator and the chip-select logic. Also runs a per-cycle watchdog that raises nBERR when no nDTACK arrives.

Parameters:
BERR_TIMEOUT, 64, clocks in ACTIVE without nDTACK before nBERR asserts (legal range 2..127)
CNT_W, 7, watchdog counter width; must hold BERR_TIMEOUT

Ports:
CLK_68KCLK  in  1  68k bus clock; all logic on the rising edge
RESET  in  1  synchronous, active-high reset
M68K_ADDR  in  23  CPU address A23..A1
nAS  in  1  address strobe, active low
M68K_RW  in  1  1 = read, 0 = write
nVEC  in  1  0 = vectors from system ROM
nDTACK  in  1  from c1_wait, active low
nROM_ZONE  out  1  0x000000-0x0FFFFF, cartridge P ROM
nWRAM_ZONE  out  1  0x100000-0x1FFFFF, work RAM (mirrored)
nPORT_ZONE  out  1  0x200000-0x2FFFFF, cartridge port
nIO_ZONE  out  1  0x300000-0x3FFFFF, I/O registers
nCARD_ZONE  out  1  0x800000-0xBFFFFF, memory card
nSROM_ZONE  out  1  0xC00000-0xCFFFFF, system ROM
nVALID  out  1  0 while a decoded cycle is in ACTIVE or HOLD
nBERR  out  1  bus error, active low
LATCHED_RW  out  1  M68K_RW captured at cycle start

Behaviour:
- Reset: state IDLE, watchdog 0, latched address 0, LATCHED_RW = 1, all zone outputs = 1, nVALID = 1, nBERR = 1. RESET overrides every other input on that edge, including mid-cycle.
- FSM states: IDLE, ACTIVE, HOLD, ERROR.
- IDLE: on an edge with nAS = 0:
  - latch M68K_ADDR and M68K_RW;
  - go to ACTIVE;
  - zones and nVALID become valid on that same registered edge, i.e. 1 clock after nAS is first sampled low.
- ACTIVE:
  - nAS = 1 takes priority -> IDLE (aborted cycle).
  - Otherwise nDTACK = 0 -> HOLD.
  - Otherwise the watchdog increments. When it would reach BERR_TIMEOUT -> ERROR, with nBERR = 0 from that edge.
- HOLD: outputs held; nAS = 1 -> IDLE.
- ERROR: nBERR held 0 and zones held; nAS = 1 -> IDLE with nBERR = 1 on that edge.
- Entering IDLE clears the watchdog and drives all zones, nVALID and nBERR to 1 on the same edge.
- A new cycle is accepted only from IDLE. nAS held low across a terminated cycle never restarts the FSM; the CPU must raise nAS first.
- Decoding uses latched A23..A20 only; outputs are registered and change only at state entry or exit.
- Vector swap: if nVEC = 0 and the latched address is below 0x000080 (A23..A7 = 0), assert nSROM_ZONE instead of nROM_ZONE.
- Unmapped ranges assert no zone but still assert nVALID; that case is timed out by the watchdog. Unmapped ranges are 0x400000-0x7FFFFF and 0xD00000-0xFFFFFF, handled by other blocks.
- At most one zone output is 0 at any time.
- Watchdog saturates; it never wraps.
- nDTACK = 0 on the edge the watchdog would hit BERR_TIMEOUT: nDTACK wins -> HOLD, no nBERR.
- nDTACK samples while IDLE are ignored.

Test Plan:
- Read 0x000400, nVEC = 1, nAS low 6 clocks, nDTACK low at clock 4 -> nROM_ZONE = 0 and nVALID = 0 from clock 1 to the clock after nAS rises; LATCHED_RW = 1; all others 1.
- Read 0x000010 with nVEC = 0 -> nSROM_ZONE = 0, nROM_ZONE = 1. Repeat at 0x000080 -> nROM_ZONE = 0.
- Write 0x8F0000 -> nCARD_ZONE = 0, LATCHED_RW = 0. M68K_ADDR changes mid-cycle to 0x100000 -> outputs unchanged.
- Cycle to 0x500000, nDTACK never asserted -> no zone low; nBERR = 0 exactly 64 clocks after ACTIVE entry. Held until nAS high, then nBERR = 1 and state IDLE.
- nDTACK asserted on the exact timeout edge -> nBERR stays 1, FSM enters HOLD.
- RESET pulsed during ACTIVE on 0x200000 -> next edge all outputs 1, watchdog 0. nAS still low -> no new cycle until nAS rises and falls again.
